// File: rtl/sar_cmp_pkg.sv
// Shared types and constants for the SAR comparator sequencer.
// Defining SAR_CMP_MAJ_VOTE_EN selects the 2-of-3 majority-vote DECIDE phase.
package sar_cmp_pkg;

    localparam int N_BITS_DEF        = 8;
    localparam int RST_CYCLES_DEF    = 1;
    localparam int SETTLE_CYCLES_DEF = 4;

`ifdef SAR_CMP_MAJ_VOTE_EN
    localparam int VOTE_N = 3;
`else
    localparam int VOTE_N = 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RESET_CMP,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

endpackage

// File: rtl/sar_cmp_sequencer_if.sv
// Host-side start/result bundle of the SAR sequencer.
// master = controller issuing conversions, slave = sequencer.
interface sar_cmp_sequencer_if #(
    parameter int N_BITS = 8
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [N_BITS-1:0] result;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sar_cmp_sequencer_cmp_sync.sv
// Two-flop synchronizer for the asynchronous comparator output.
// Both stages clear to 0 on reset.
module cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    // Shift the raw input through two flops before it reaches logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sar_cmp_sequencer.sv
// Successive-approximation sequencer driving a latched comparator and DAC.
// Optional build macro: SAR_CMP_MAJ_VOTE_EN (3-sample majority DECIDE).
module sar_cmp_sequencer
    import sar_cmp_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sar_cmp_sequencer_if.slave   host,
    input  logic                 cmp_in,
    output logic                 cmp_en,
    output logic [N_BITS-1:0]    dac_code
);
    localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [KW-1:0] K_TOP  = KW'(N_BITS - 1);
    localparam logic [7:0]    R_LAST = 8'(RST_CYCLES - 1);
    localparam logic [7:0]    S_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    V_LAST = 8'(VOTE_N - 1);
    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cnt;
    logic [KW-1:0]     k;
    logic [N_BITS-1:0] w;
    logic [N_BITS-1:0] w_new;
    logic [N_BITS-1:0] trial_nxt;
    logic [N_BITS-1:0] result_q;
    logic [N_BITS-1:0] dac_q;
    logic              cmp_s;
    logic              bit_val;
    logic              busy;
    logic              done;

    cmp_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cmp_in),
        .q     (cmp_s)
    );

`ifdef SAR_CMP_MAJ_VOTE_EN
    logic [1:0] ones;
    assign bit_val = (ones + {1'b0, cmp_s}) >= 2'd2;
`else
    assign bit_val = cmp_s;
`endif

    // The next trial keeps decided bits and sets the bit below k (none at k=0).
    assign w_new     = w | (bit_val ? (ONE << k) : '0);
    assign trial_nxt = w_new | ((ONE << k) >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every transition outside IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (host.start && !host.abort) state_nxt = RESET_CMP;
            RESET_CMP: if (cnt == R_LAST) state_nxt = SETTLE;
            SETTLE:    if (cnt == S_LAST) state_nxt = DECIDE;
            DECIDE:    if (cnt == V_LAST)
                           state_nxt = (k == '0) ? DONE : RESET_CMP;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (host.abort && state != IDLE) state_nxt = IDLE;
    end

    // Outputs decoded from state; comparator evaluates through DECIDE.
    always_comb begin
        cmp_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state)
            IDLE:      ;
            RESET_CMP: busy = 1'b1;
            SETTLE:    begin busy = 1'b1; cmp_en = 1'b1; end
            DECIDE:    begin busy = 1'b1; cmp_en = 1'b1; end
            DONE:      begin busy = 1'b1; done = 1'b1; end
            default:   ;
        endcase
    end

    // Datapath: phase counter, bit index, working register, DAC and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            k        <= K_TOP;
            w        <= '0;
            dac_q    <= '0;
            result_q <= '0;
        end else begin
            cnt <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            if (state == IDLE && state_nxt == RESET_CMP) begin
                w     <= '0;
                k     <= K_TOP;
                dac_q <= ONE << K_TOP;
            end else if (state != IDLE && state_nxt == IDLE) begin
                dac_q <= '0;
            end else if (state == DECIDE && state_nxt == RESET_CMP) begin
                w     <= w_new;
                k     <= k - KW'(1);
                dac_q <= trial_nxt;
            end else if (state == DECIDE && state_nxt == DONE) begin
                w        <= w_new;
                result_q <= w_new;
                dac_q    <= '0;
            end
        end
    end

`ifdef SAR_CMP_MAJ_VOTE_EN
    // Count ones seen in the earlier DECIDE samples of this bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ones <= '0;
        else if (state == DECIDE)
            ones <= (cnt == 8'd0) ? {1'b0, cmp_s} : ones + {1'b0, cmp_s};
    end
`endif

    assign dac_code    = dac_q;
    assign host.busy   = busy;
    assign host.done   = done;
    assign host.result = result_q;

endmodule

// File: tb/tb_sar_cmp_sequencer.sv
// Randomized self-checking bench for sar_cmp_sequencer.
// An ideal comparator model answers (vin >= dac_code) while enabled.
module tb_sar_cmp_sequencer;
    localparam int N = 8;
    localparam int R = 1;
    localparam int S = 4;
`ifdef SAR_CMP_MAJ_VOTE_EN
    localparam int V = 3;
`else
    localparam int V = 1;
`endif
    localparam int P       = R + S + V;
    localparam int EXP_LAT = N * P + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmp_in;
    logic         cmp_en;
    logic [N-1:0] dac_code;
    logic [N-1:0] vin = '0;
    logic         glitch = 1'b0;
    logic         glitch_on = 1'b0;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int hi_cnt = 0;
    logic [N-1:0] dac_log[$];
    logic [N-1:0] last_dac = '0;
    logic [N-1:0] prev_dac = '0;
    logic         prev_en = 1'b0;

    sar_cmp_sequencer_if #(.N_BITS(N)) bus ();

    sar_cmp_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (bus),
        .cmp_in   (cmp_in),
        .cmp_en   (cmp_en),
        .dac_code (dac_code)
    );

    always #5 clk = ~clk;

    assign cmp_in = (cmp_en && (vin >= dac_code)) ^ glitch;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Monitor: done pulses, trial-code log, DAC stability while enabled.
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (dac_code != last_dac && dac_code != '0)
            dac_log.push_back(dac_code);
        if (cmp_en && prev_en)
            chk("dac_stable", 32'(dac_code), 32'(prev_dac));
        last_dac = dac_code;
        prev_dac = dac_code;
        prev_en  = cmp_en;
    end

    // Glitch injector: inverts cmp_in for one cycle in the first DECIDE cycle.
    always @(negedge clk) begin
        hi_cnt = cmp_en ? hi_cnt + 1 : 0;
        glitch = glitch_on && cmp_en && (hi_cnt == S + 1);
    end

    task automatic begin_conv(input logic [N-1:0] v);
        vin = v;
        dac_log.delete();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic convert(input logic [N-1:0] v, input bit re_start);
        int edges;
        int lat;
        int d0;
        logic [N-1:0] acc;
        logic [N-1:0] code;
        d0 = done_cnt;
        begin_conv(v);
        edges = 0;
        lat = -1;
        for (int i = 0; i < 4 * EXP_LAT; i++) begin
            if (bus.done) begin
                lat = edges + 1;
                break;
            end
            if (re_start && i == 10) bus.start = 1'b1;
            if (i == 11) bus.start = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(EXP_LAT));
        chk("result", 32'(bus.result), 32'(v));
        if (re_start) bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("one_done", 32'(done_cnt - d0), 32'd1);
        chk("dac_count", 32'(dac_log.size()), 32'(N));
        acc = '0;
        for (int b = N - 1; b >= 0; b--) begin
            code = acc | (N'(1) << b);
            if (N - 1 - b < dac_log.size())
                chk("dac_seq", 32'(dac_log[N - 1 - b]), 32'(code));
            if (v >= code) acc = code;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
`ifdef SAR_CMP_MAJ_VOTE_EN
        glitch_on = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_cmp_en", 32'(cmp_en), 32'd0);
        chk("rst_dac", 32'(dac_code), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        convert(8'hA5, 1'b0);
        convert(8'h00, 1'b0);
        convert(8'hFF, 1'b1);
        convert(8'hA5, 1'b0);

        begin
            int d0;
            d0 = done_cnt;
            begin_conv(8'h3C);
            repeat (4 * P + R + 1) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_cmp_en", 32'(cmp_en), 32'd0);
            chk("abort_dac", 32'(dac_code), 32'd0);
            chk("abort_result", 32'(bus.result), 32'hA5);
            repeat (2 * EXP_LAT) @(negedge clk);
            chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        end

        vin = 8'h11;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", 32'(bus.busy), 32'd0);

        begin_conv(8'h3C);
        repeat (R + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_cmp_en", 32'(cmp_en), 32'd0);
        chk("arst_dac", 32'(dac_code), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(8'h5A, 1'b0);

        for (int i = 0; i < 10; i++)
            convert(N'($urandom), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
